// File: rtl/dmux16_stream.sv
// dmux16_stream: 1-to-2 packet stream demultiplexer.
// A packet is routed to channel A or B according to in_sel on its first
// word; the route is then locked until the word carrying in_last. Each
// channel owns a one-word holding register that runs at full throughput
// and counts the words it delivers.

module dmux16_chan #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic xfer;

    assign xfer = valid && ready;

    // Holding register: a load wins over a drain, so a word leaving and a
    // word arriving in the same cycle keeps valid high with the new data.
    // The parent only loads when the register is empty or draining, so a
    // stalled word is never overwritten.
    always_ff @(posedge clock) begin
        if (reset) begin
            data  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= ld_data;
            last  <= ld_last;
            valid <= 1'b1;
        end else if (xfer) begin
            valid <= 1'b0;
        end
    end

    // Delivered-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (xfer)
            count <= count + 1'b1;
    end

endmodule

module dmux16_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] b_count
);

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t                        state;
    logic                          route;     // 0 = A, 1 = B
    logic                          in_xfer;
    logic [NUM_CH-1:0]             ch_load;
    logic [NUM_CH-1:0]             ch_ready;
    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0]             ch_last;
    logic [NUM_CH-1:0][WIDTH-1:0]  ch_data;
    logic [NUM_CH-1:0][CNT_W-1:0]  ch_count;

    // in_sel only steers the first word of a packet; locked states pin the route.
    assign route    = (state == IDLE) ? in_sel : (state == LOCK_B);

    // Only the routed channel's occupancy gates the input.
    assign in_ready = !ch_valid[route] || ch_ready[route];
    assign in_xfer  = in_valid && in_ready;

    assign ch_load[0] = in_xfer && !route;
    assign ch_load[1] = in_xfer &&  route;
    assign ch_ready   = {b_ready, a_ready};

    // Packet lock FSM: a non-last word opened in IDLE locks the route until
    // the last word of the packet is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (in_xfer) begin
            case (state)
                IDLE:    if (!in_last) state <= in_sel ? LOCK_B : LOCK_A;
                default: if (in_last)  state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            dmux16_chan #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_chan (
                .clock   (clock),
                .reset   (reset),
                .load    (ch_load[g]),
                .ld_data (in_data),
                .ld_last (in_last),
                .ready   (ch_ready[g]),
                .data    (ch_data[g]),
                .last    (ch_last[g]),
                .valid   (ch_valid[g]),
                .count   (ch_count[g])
            );
        end
    endgenerate

    assign a_data  = ch_data[0];
    assign a_last  = ch_last[0];
    assign a_valid = ch_valid[0];
    assign a_count = ch_count[0];
    assign b_data  = ch_data[1];
    assign b_last  = ch_last[1];
    assign b_valid = ch_valid[1];
    assign b_count = ch_count[1];

endmodule

// File: tb/tb_dmux16_stream.sv
// Bench for dmux16_stream: table of routed words checked through per-channel
// scoreboards, plus hand-written sequences for latency, backpressure,
// channel independence, reset mid-packet and counter wrap.

module tb_dmux16_stream;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_sel = 1'b0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_last, b_last, a_valid, b_valid;
    logic             a_ready = 1'b1;
    logic             b_ready = 1'b1;
    logic [CNT_W-1:0] a_count, b_count;

    dmux16_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_last   (a_last),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_count  (a_count),
        .b_data   (b_data),
        .b_last   (b_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_count  (b_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sel;
        logic             last;
        logic             ch;     // expected destination: 0 = A, 1 = B
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: a word leaving a channel must match the oldest word the
    // stimulus sent to that channel.
    always @(negedge clock) begin
        if (!reset && a_valid && a_ready) begin
            if (qa.size() == 0) check("a_unexpected", 32'(a_data), 32'hFFFF_FFFF);
            else begin
                ea = qa.pop_front();
                check("a_data", 32'(a_data), 32'(ea.data));
                check("a_last", 32'(a_last), 32'(ea.last));
            end
        end
        if (!reset && b_valid && b_ready) begin
            if (qb.size() == 0) check("b_unexpected", 32'(b_data), 32'hFFFF_FFFF);
            else begin
                eb = qb.pop_front();
                check("b_data", 32'(b_data), 32'(eb.data));
                check("b_last", 32'(b_last), 32'(eb.last));
            end
        end
    end

    // Drive one word (starting just after a rising edge), wait boundedly for
    // acceptance, and record where it must come out.
    task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic l, input logic ch);
        int n = 0;
        in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        else if (ch) qb.push_back('{d, l});
        else         qa.push_back('{d, l});
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h1234, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{16'hA001, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'hA002, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hA003, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'hB001, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'hB002, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'hB003, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{16'hA004, 1'b0, 1'b1, 1'b0};

        // Reset with a live handshake on the input: reset must win.
        in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1; in_sel = 1'b0;
        cycles(2);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_a_data",  32'(a_data),  32'd0);
        check("rst_b_data",  32'(b_data),  32'd0);
        check("rst_a_last",  32'(a_last),  32'd0);
        check("rst_b_last",  32'(b_last),  32'd0);
        check("rst_a_count", 32'(a_count), 32'd0);
        check("rst_b_count", 32'(b_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;

        // Single-word latency: valid on B one cycle after acceptance, counted the next.
        send(16'h1234, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        check("single_b_valid", 32'(b_valid), 32'd1);
        check("single_b_data",  32'(b_data),  32'h1234);
        check("single_a_valid", 32'(a_valid), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check("single_b_count", 32'(b_count), 32'd1);
        @(posedge clock); #1;

        // Table: packet lock on A despite in_sel toggles, then B traffic, back to A.
        for (int i = 1; i < 8; i++)
            send(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].ch);
        cycles(2);
        check("tbl_a_count", 32'(a_count), 32'd4);
        check("tbl_b_count", 32'(b_count), 32'd4);

        // Backpressure on A: second word waits, then loads as the first drains.
        a_ready = 1'b0;
        send(16'hC001, 1'b0, 1'b1, 1'b0);
        in_data = 16'hC002; in_sel = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_a_data",   32'(a_data),   32'hC001);
        @(posedge clock); #1;
        @(negedge clock);
        check("bp_hold_data",  32'(a_data),  32'hC001);
        check("bp_hold_valid", 32'(a_valid), 32'd1);
        @(posedge clock); #1;
        a_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        qa.push_back('{16'hC002, 1'b1});
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("bp_a_valid_kept", 32'(a_valid), 32'd1);
        check("bp_a_data_new",   32'(a_data),  32'hC002);
        @(posedge clock); #1;

        // Independence: B stalled with a word, A packet still flows.
        b_ready = 1'b0;
        send(16'hD001, 1'b1, 1'b1, 1'b1);
        send(16'hD101, 1'b0, 1'b0, 1'b0);
        send(16'hD102, 1'b1, 1'b1, 1'b0);
        cycles(1);
        @(negedge clock);
        check("ind_b_data",  32'(b_data),  32'hD001);
        check("ind_b_valid", 32'(b_valid), 32'd1);
        @(posedge clock); #1;
        b_ready = 1'b1;
        cycles(2);

        // Reset mid-packet while locked on B with a held word.
        b_ready = 1'b0;
        send(16'hE001, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        qb.delete();
        b_ready = 1'b1;
        @(negedge clock);
        check("mid_a_valid", 32'(a_valid), 32'd0);
        check("mid_b_valid", 32'(b_valid), 32'd0);
        check("mid_a_count", 32'(a_count), 32'd0);
        check("mid_b_count", 32'(b_count), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        send(16'hE002, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("mid_route_a",  32'(a_valid), 32'd1);
        check("mid_a_data",   32'(a_data),  32'hE002);
        check("mid_b_idle",   32'(b_valid), 32'd0);
        @(posedge clock); #1;

        // Counter wrap on B after 256 deliveries.
        for (int i = 0; i < 255; i++)
            send(16'(i), 1'b1, 1'b1, 1'b1);
        cycles(2);
        check("wrap_b_255", 32'(b_count), 32'd255);
        send(16'h5A5A, 1'b1, 1'b1, 1'b1);
        cycles(2);
        check("wrap_b_0",   32'(b_count), 32'd0);
        check("wrap_a_cnt", 32'(a_count), 32'd1);

        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
